// File: rtl/fifo_flex.sv
// fifo_flex: single-clock first-word fall-through FIFO of any depth, with occupancy count,
// almost-full/almost-empty flags and synchronous flush. Define FIFO_FLEX_ERR_FLAGS_EN for sticky overflow/underflow.
module fifo_flex #(
   parameter  int DATA_WIDTH = 8,
   parameter  int FIFO_DEPTH = 4,
   parameter  int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter  int AE_LEVEL   = 1,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  enq,
   output logic                  full_n,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  deq,
   output logic                  empty_n,
   output logic                  almost_full_n,
   output logic                  almost_empty_n,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt_q;
   logic                  enq_ok;
   logic                  deq_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Status is decoded from the registered count only, never from enq/deq.
   assign full_n         = (cnt_q != CNT_W'(FIFO_DEPTH));
   assign empty_n        = (cnt_q != '0);
   assign almost_full_n  = !(cnt_q >= CNT_W'(AF_LEVEL));
   assign almost_empty_n = !(cnt_q <= CNT_W'(AE_LEVEL));
   assign count          = cnt_q;
   assign dout           = mem[rd_ptr];

   assign enq_ok = enq && full_n && !clr;
   assign deq_ok = deq && empty_n && !clr;

   always_ff @(posedge clk) begin
      if (enq_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (enq_ok) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (deq_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (enq_ok && !deq_ok) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (deq_ok && !enq_ok) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

`ifdef FIFO_FLEX_ERR_FLAGS_EN
   logic ovf_q;
   logic unf_q;

   // Sticky until reset; a flush deliberately leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (enq && !full_n) begin
            ovf_q <= 1'b1;
         end
         if (deq && !empty_n) begin
            unf_q <= 1'b1;
         end
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
